// File: rtl/down_counter16.sv
// Loadable, enable-gated down-counter with a one-cycle terminal-count pulse
// and optional auto-reload of the last loaded value.
module down_counter16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             auto_reload_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             busy_o,
  output logic             tc_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // State, count, reload value and terminal pulse registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic; load overrides counting in either state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load_i) begin
      cnt_d    = load_val_i;
      reload_d = load_val_i;
      if (load_val_i != '0) begin
        state_d = RUN;
      end else begin
        // Zero-length interval completes immediately
        state_d = IDLE;
        tc_d    = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (en_i) begin
            if (cnt_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (auto_reload_i) begin
                cnt_d = reload_q;
              end else begin
                cnt_d   = '0;
                state_d = IDLE;
              end
            end else begin
              cnt_d = cnt_q - WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (state_q == RUN);
  assign tc_o   = tc_q;

endmodule

// File: tb/tb_down_counter16.sv
// Directed bench for down_counter16: reset, countdown, gating, auto-reload,
// load priority, zero/max loads and asynchronous reset.
module tb_down_counter16;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             tc;

  int checks = 0;
  int errors = 0;

  down_counter16 #(.WIDTH(WIDTH)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .load_i        (load),
    .load_val_i    (load_val),
    .en_i          (en),
    .auto_reload_i (auto_reload),
    .cnt_o         (cnt),
    .busy_o        (busy),
    .tc_o          (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
    cycle();
    cycle();
    checks++;
    if (cnt !== 16'h0 || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: cnt=%h busy=%b tc=%b expected 0/0/0", cnt, busy, tc);
    end
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (cnt !== 16'h0 || busy !== 1'b0 || tc !== 1'b0) begin
        errors++;
        $display("FAIL idle_en[%0d]: cnt=%h busy=%b tc=%b expected 0/0/0", i, cnt, busy, tc);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_countdown();
    logic [WIDTH-1:0] exp_cnt [6];
    exp_cnt = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    auto_reload = 1'b0;
    en       = 1'b1;
    load     = 1'b1;
    load_val = 16'h0005;
    for (int i = 0; i < 6; i++) begin
      cycle();
      load = 1'b0;
      checks++;
      if (cnt !== exp_cnt[i] || tc !== (i == 5) || busy !== (i != 5)) begin
        errors++;
        $display("FAIL countdown[%0d]: cnt=%h tc=%b busy=%b expected %h/%b/%b",
                 i, cnt, tc, busy, exp_cnt[i], (i == 5), (i != 5));
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (cnt !== 16'h0 || tc !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL countdown_stop[%0d]: cnt=%h tc=%b busy=%b expected 0/0/0", i, cnt, tc, busy);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_autoreload();
    logic             en_seq  [8];
    logic [WIDTH-1:0] exp_cnt [8];
    logic             exp_tc  [8];
    en_seq  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_cnt = '{16'd2, 16'd2, 16'd1, 16'd3, 16'd3, 16'd2, 16'd1, 16'd3};
    exp_tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    auto_reload = 1'b1;
    load     = 1'b1;
    load_val = 16'h0003;
    en       = 1'b0;
    cycle();
    load = 1'b0;
    checks++;
    if (cnt !== 16'd3 || busy !== 1'b1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reload_load: cnt=%h busy=%b tc=%b expected 0003/1/0", cnt, busy, tc);
    end
    for (int i = 0; i < 8; i++) begin
      en = en_seq[i];
      cycle();
      checks++;
      if (cnt !== exp_cnt[i] || tc !== exp_tc[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL reload_step[%0d]: cnt=%h tc=%b busy=%b expected %h/%b/1",
                 i, cnt, tc, busy, exp_cnt[i], exp_tc[i]);
      end
    end
    en = 1'b0;
    auto_reload = 1'b0;
  endtask

  task automatic test_load_priority();
    load     = 1'b1;
    load_val = 16'h0002;
    en       = 1'b1;
    cycle();
    load = 1'b0;
    cycle();
    checks++;
    if (cnt !== 16'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_pre: cnt=%h busy=%b expected 0001/1", cnt, busy);
    end
    load     = 1'b1;
    load_val = 16'h1234;
    cycle();
    load = 1'b0;
    en   = 1'b0;
    checks++;
    if (cnt !== 16'h1234 || tc !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_load: cnt=%h tc=%b busy=%b expected 1234/0/1", cnt, tc, busy);
    end
  endtask

  task automatic test_zero_max();
    int tc_count;
    load     = 1'b1;
    load_val = 16'h0000;
    en       = 1'b0;
    cycle();
    load = 1'b0;
    checks++;
    if (cnt !== 16'h0 || tc !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_load: cnt=%h tc=%b busy=%b expected 0000/1/0", cnt, tc, busy);
    end
    cycle();
    checks++;
    if (tc !== 1'b0) begin
      errors++;
      $display("FAIL zero_tc_width: tc=%b expected 0", tc);
    end

    load     = 1'b1;
    load_val = 16'hFFFF;
    cycle();
    load = 1'b0;
    checks++;
    if (cnt !== 16'hFFFF || busy !== 1'b1) begin
      errors++;
      $display("FAIL max_load: cnt=%h busy=%b expected ffff/1", cnt, busy);
    end
    en = 1'b1;
    tc_count = 0;
    for (int i = 0; i < 65535; i++) begin
      cycle();
      if (tc === 1'b1) tc_count++;
    end
    checks++;
    if (cnt !== 16'h0 || tc !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL max_end: cnt=%h tc=%b busy=%b expected 0000/1/0", cnt, tc, busy);
    end
    checks++;
    if (tc_count !== 1) begin
      errors++;
      $display("FAIL max_tc_count: got %0d pulses expected 1", tc_count);
    end
    cycle();
    checks++;
    if (cnt !== 16'h0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL max_no_wrap: cnt=%h tc=%b expected 0000/0", cnt, tc);
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    load     = 1'b1;
    load_val = 16'h00FF;
    en       = 1'b0;
    cycle();
    load = 1'b0;
    en   = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (cnt !== 16'h00F5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: cnt=%h busy=%b expected 00f5/1", cnt, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cnt !== 16'h0 || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL async_now: cnt=%h busy=%b tc=%b expected 0/0/0", cnt, busy, tc);
    end
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (cnt !== 16'h0 || busy !== 1'b0 || tc !== 1'b0) begin
        errors++;
        $display("FAIL async_after[%0d]: cnt=%h busy=%b tc=%b expected 0/0/0", i, cnt, busy, tc);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_autoreload();
    test_load_priority();
    test_zero_max();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
